// File: rtl/shift_left_seq.sv
// Multi-cycle logical left shifter: shifts A left by B positions, STEP bits per clock,
// with a start/busy/done handshake. Any shift amount of 32 or more yields zero.
module shift_left_seq #(
    parameter int STEP = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0] STEP_AMT = 6'(STEP);

    state_t      state_reg, state_next;
    logic [31:0] work_reg, work_next;
    logic [31:0] result_reg, result_next;
    logic [5:0]  count_reg, count_next;

    logic [5:0]  amount;
    logic [5:0]  step_amt;
    logic [5:0]  remaining;
    logic [31:0] shifted;
    logic        accept;

    generate
        if (STEP < 1 || STEP > 32) begin : g_bad_step
            $error("shift_left_seq: STEP must be in the range 1..32");
        end
    endgenerate

    // Any set bit above bit 4 means the amount is at least 32: saturate rather than wrap.
    assign amount    = (|B[31:5]) ? 6'd32 : {1'b0, B[4:0]};
    assign step_amt  = (count_reg < STEP_AMT) ? count_reg : STEP_AMT;
    assign shifted   = work_reg << step_amt;
    assign remaining = count_reg - step_amt;
    assign accept    = start && (state_reg != SHIFT);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg  <= IDLE;
            work_reg   <= '0;
            result_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            work_reg   <= work_next;
            result_reg <= result_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        work_next   = work_reg;
        result_next = result_reg;
        count_next  = count_reg;

        case (state_reg)
            IDLE, DONE: begin
                // DONE accepts a new request directly so held-high start runs back-to-back.
                if (accept) begin
                    work_next  = A;
                    count_next = amount;
                    if (amount == 6'd0) begin
                        result_next = A;
                        state_next  = DONE;
                    end else begin
                        state_next  = SHIFT;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                work_next  = shifted;
                count_next = remaining;
                if (remaining == 6'd0) begin
                    result_next = shifted;
                    state_next  = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign result = result_reg;
    assign busy   = (state_reg == SHIFT);
    assign done   = (state_reg == DONE);

endmodule

// File: tb/tb_shift_left_seq.sv
// Bench for shift_left_seq: table-driven vectors run on STEP=1 and STEP=4 instances,
// plus hand-written sequences for handshake and reset corner cases.
module tb_shift_left_seq;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] result1, result4;
    logic        busy1, busy4, done1, done4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    shift_left_seq #(.STEP(1)) dut1 (
        .clock (clock),
        .clear (clear),
        .start (start1),
        .A     (A),
        .B     (B),
        .result(result1),
        .busy  (busy1),
        .done  (done1)
    );

    shift_left_seq #(.STEP(4)) dut4 (
        .clock (clock),
        .clear (clear),
        .start (start4),
        .A     (A),
        .B     (B),
        .result(result4),
        .busy  (busy4),
        .done  (done4)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat1;
        int          lat4;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        int          cyc;
        bit          got1, got4;
        int          lat1, lat4, bcnt1, bcnt4;
        logic [31:0] res1, res4;
        int          seen;

        // A, B, expected result, edges to done for STEP=1, edges to done for STEP=4
        vecs[0]  = '{32'h0000_0001, 32'd4,         32'h0000_0010, 5,  2};
        vecs[1]  = '{32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1,  1};
        vecs[2]  = '{32'hFFFF_FFFF, 32'd40,        32'h0000_0000, 33, 9};
        vecs[3]  = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0000, 33, 9};
        vecs[4]  = '{32'hFFFF_FFFF, 32'd7,         32'hFFFF_FF80, 8,  3};
        vecs[5]  = '{32'h0000_0003, 32'd31,        32'h8000_0000, 32, 9};
        vecs[6]  = '{32'h0000_ABCD, 32'd16,        32'hABCD_0000, 17, 5};
        vecs[7]  = '{32'h8000_0001, 32'd32,        32'h0000_0000, 33, 9};
        vecs[8]  = '{32'h1234_5678, 32'd33,        32'h0000_0000, 33, 9};
        vecs[9]  = '{32'h1234_5678, 32'd4,         32'h2345_6780, 5,  2};
        vecs[10] = '{32'h0F0F_0F0F, 32'd1,         32'h1E1E_1E1E, 2,  2};
        vecs[11] = '{32'hA5A5_A5A5, 32'h0000_0100, 32'h0000_0000, 33, 9};

        // Reset and idle
        #1;
        check("reset_result1", result1, 32'h0);
        check("reset_busy1", {31'b0, busy1}, 32'h0);
        check("reset_done1", {31'b0, done1}, 32'h0);
        check("reset_result4", result4, 32'h0);
        @(negedge clock);
        clear = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (result1 != 0 || busy1 || done1 || result4 != 0 || busy4 || done4) seen++;
        end
        check("idle_10_cycles_quiet", 32'(seen), 32'h0);

        // Table-driven vectors, both instances in parallel
        for (int v = 0; v < 12; v++) begin
            @(negedge clock);
            A = vecs[v].a;
            B = vecs[v].b;
            start1 = 1'b1;
            start4 = 1'b1;
            cyc = 0; got1 = 0; got4 = 0;
            lat1 = 0; lat4 = 0; bcnt1 = 0; bcnt4 = 0; res1 = 'x; res4 = 'x;
            while (!(got1 && got4) && cyc < 60) begin
                @(posedge clock); #1;
                cyc++;
                if (cyc == 1) begin
                    start1 = 1'b0;
                    start4 = 1'b0;
                end
                if (busy1) bcnt1++;
                if (busy4) bcnt4++;
                if (done1 && !got1) begin got1 = 1; lat1 = cyc; res1 = result1; end
                if (done4 && !got4) begin got4 = 1; lat4 = cyc; res4 = result4; end
            end
            check($sformatf("v%0d_result_step1", v), res1, vecs[v].res);
            check($sformatf("v%0d_latency_step1", v), 32'(lat1), 32'(vecs[v].lat1));
            check($sformatf("v%0d_busycycles_step1", v), 32'(bcnt1), 32'(vecs[v].lat1 - 1));
            check($sformatf("v%0d_result_step4", v), res4, vecs[v].res);
            check($sformatf("v%0d_latency_step4", v), 32'(lat4), 32'(vecs[v].lat4));
            check($sformatf("v%0d_busycycles_step4", v), 32'(bcnt4), 32'(vecs[v].lat4 - 1));
            $display("vector %0d: A=0x%08h B=0x%08h -> r1=0x%08h lat1=%0d r4=0x%08h lat4=%0d",
                     v, vecs[v].a, vecs[v].b, res1, lat1, res4, lat4);
            @(posedge clock); #1;
        end

        // start pulsed while busy must be ignored
        @(negedge clock);
        A = 32'h0000_000F; B = 32'd3; start1 = 1'b1;
        @(posedge clock); #1;
        A = 32'h1234_5678; B = 32'd0;
        @(posedge clock); #1;
        start1 = 1'b0;
        check("ignore_busy_no_early_done", {31'b0, done1}, 32'h0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("ignore_busy_done_edge4", {31'b0, done1}, 32'h1);
        check("ignore_busy_result", result1, 32'h0000_0078);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (done1 || busy1 || result1 != 32'h0000_0078) seen++;
        end
        check("ignore_busy_no_queued_op", 32'(seen), 32'h0);
        $display("ignore-while-busy: result=0x%08h", result1);

        // start held across DONE: back-to-back without an idle cycle
        @(negedge clock);
        A = 32'h0000_0001; B = 32'd2; start1 = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("b2b_first_done", {31'b0, done1}, 32'h1);
        check("b2b_first_result", result1, 32'h0000_0004);
        A = 32'h0000_0003; B = 32'd1;
        @(posedge clock); #1;
        start1 = 1'b0;
        check("b2b_second_busy_immediately", {31'b0, busy1}, 32'h1);
        @(posedge clock); #1;
        check("b2b_second_done", {31'b0, done1}, 32'h1);
        check("b2b_second_result", result1, 32'h0000_0006);
        $display("back-to-back: result=0x%08h", result1);

        // STEP=4 with zero shift held high: done on consecutive cycles
        @(negedge clock);
        A = 32'h0000_0005; B = 32'd0; start4 = 1'b1;
        @(posedge clock); #1;
        check("zero_b2b_done1", {31'b0, done4}, 32'h1);
        check("zero_b2b_result1", result4, 32'h0000_0005);
        A = 32'h0000_0006;
        @(posedge clock); #1;
        start4 = 1'b0;
        check("zero_b2b_done2", {31'b0, done4}, 32'h1);
        check("zero_b2b_result2", result4, 32'h0000_0006);
        @(posedge clock); #1;
        check("zero_b2b_back_to_idle", {31'b0, done4}, 32'h0);
        $display("zero-shift back-to-back: result=0x%08h", result4);

        // Asynchronous clear in the middle of a shift
        @(negedge clock);
        A = 32'hFFFF_FFFF; B = 32'd20; start1 = 1'b1;
        @(posedge clock); #1;
        start1 = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        check("clear_pre_busy", {31'b0, busy1}, 32'h1);
        @(negedge clock);
        #1;
        clear = 1'b0;
        #1;
        check("clear_async_result", result1, 32'h0);
        check("clear_async_busy", {31'b0, busy1}, 32'h0);
        check("clear_async_done", {31'b0, done1}, 32'h0);
        @(negedge clock);
        clear = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (done1 || busy1) seen++;
        end
        check("clear_no_done_after", 32'(seen), 32'h0);
        $display("mid-shift clear: result=0x%08h", result1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
